// File: rtl/execute_stage_pkg.sv
// execute_stage_pkg: shared widths, encodings and forwarding helper for the execute stage
package execute_stage_pkg;

    localparam int WORD_SIZE = 32;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic [WORD_SIZE-1:0] alu_result;
        logic [WORD_SIZE-1:0] write_data;
        logic [WORD_SIZE-1:0] pc_plus4;
        logic [4:0]           rd;
        logic                 reg_write;
        logic                 mem_write;
        logic [1:0]           result_src;
    } exmem_t;

    // MEM beats WB; x0 never forwards; a load in MEM holds an address, so it is skipped
    function automatic fwd_sel_e fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       wr_m,
        input logic       load_m,
        input logic [4:0] rd_w,
        input logic       wr_w
    );
        return (wr_m && !load_m && rd_m != 5'd0 && rd_m == rs) ? FWD_MEM :
               (wr_w && rd_w != 5'd0 && rd_w == rs)            ? FWD_WB  : FWD_REG;
    endfunction

endpackage

// File: rtl/execute_stage_alu.sv
// execute_stage_alu: combinational ALU with zero flag
module execute_stage_alu
    import execute_stage_pkg::*;
(
    input  logic [WORD_SIZE-1:0] src_a_i,
    input  logic [WORD_SIZE-1:0] src_b_i,
    input  logic [2:0]           alu_control_i,
    output logic [WORD_SIZE-1:0] result_o,
    output logic                 zero_o
);

    // operation select; shifts use the low five bits of SrcB
    always_comb begin
        result_o = '0;
        case (alu_control_i)
            ALU_ADD: result_o = src_a_i + src_b_i;
            ALU_SUB: result_o = src_a_i - src_b_i;
            ALU_AND: result_o = src_a_i & src_b_i;
            ALU_OR:  result_o = src_a_i | src_b_i;
            ALU_XOR: result_o = src_a_i ^ src_b_i;
            ALU_SLT: result_o = {{(WORD_SIZE-1){1'b0}}, $signed(src_a_i) < $signed(src_b_i)};
            ALU_SLL: result_o = src_a_i << src_b_i[4:0];
            ALU_SRL: result_o = src_a_i >> src_b_i[4:0];
            default: result_o = '0;
        endcase
        zero_o = (result_o == '0);
    end

endmodule

// File: rtl/execute_stage.sv
// execute_stage: operand forwarding, ALU, branch resolution and EX/MEM register
module execute_stage
    import execute_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] RD1E,
    input  logic [WORD_SIZE-1:0] RD2E,
    input  logic [WORD_SIZE-1:0] PCE,
    input  logic [WORD_SIZE-1:0] PCPlus4E,
    input  logic [WORD_SIZE-1:0] ImmExtE,
    input  logic [4:0]           Rs1E,
    input  logic [4:0]           Rs2E,
    input  logic [4:0]           RdE,
    input  logic                 RegWriteE,
    input  logic                 MemWriteE,
    input  logic                 JumpE,
    input  logic                 BranchE,
    input  logic                 ALUSrcE,
    input  logic [1:0]           ResultSrcE,
    input  logic [2:0]           ALUControlE,
    input  logic [WORD_SIZE-1:0] ResultW,
    input  logic [4:0]           RdW,
    input  logic                 RegWriteW,
    output logic                 PCSrcE,
    output logic [WORD_SIZE-1:0] PCTargetE,
    output logic [WORD_SIZE-1:0] ALUResultM,
    output logic [WORD_SIZE-1:0] WriteDataM,
    output logic [WORD_SIZE-1:0] PCPlus4M,
    output logic [4:0]           RdM,
    output logic                 RegWriteM,
    output logic                 MemWriteM,
    output logic [1:0]           ResultSrcM
);

    exmem_t               exmem_d, exmem_q;
    fwd_sel_e             fwd_a, fwd_b;
    logic [WORD_SIZE-1:0] src_a, src_b, write_data, alu_result;
    logic                 zero;

    // forwarding muxes and ALU operand B select
    always_comb begin
        fwd_a      = fwd_sel(Rs1E, RdM, RegWriteM, ResultSrcM == RES_MEM, RdW, RegWriteW);
        fwd_b      = fwd_sel(Rs2E, RdM, RegWriteM, ResultSrcM == RES_MEM, RdW, RegWriteW);
        src_a      = fwd_a == FWD_MEM ? ALUResultM : fwd_a == FWD_WB ? ResultW : RD1E;
        write_data = fwd_b == FWD_MEM ? ALUResultM : fwd_b == FWD_WB ? ResultW : RD2E;
        src_b      = ALUSrcE ? ImmExtE : write_data;
    end

    execute_stage_alu u_alu (
        .src_a_i       (src_a),
        .src_b_i       (src_b),
        .alu_control_i (ALUControlE),
        .result_o      (alu_result),
        .zero_o        (zero)
    );

    assign PCSrcE    = JumpE | (BranchE & zero);
    assign PCTargetE = PCE + ImmExtE;

    // next EX/MEM contents straight from this cycle's E instruction
    always_comb begin
        exmem_d = '{alu_result: alu_result, write_data: write_data, pc_plus4: PCPlus4E,
                    rd: RdE, reg_write: RegWriteE, mem_write: MemWriteE, result_src: ResultSrcE};
    end

    // EX/MEM register; reset discards the in-flight instruction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) exmem_q <= '0;
        else      exmem_q <= exmem_d;
    end

    assign ALUResultM = exmem_q.alu_result;
    assign WriteDataM = exmem_q.write_data;
    assign PCPlus4M   = exmem_q.pc_plus4;
    assign RdM        = exmem_q.rd;
    assign RegWriteM  = exmem_q.reg_write;
    assign MemWriteM  = exmem_q.mem_write;
    assign ResultSrcM = exmem_q.result_src;

endmodule
